// File: rtl/mem_stage.sv
// Memory-access stage: holds the execute payload until its data-SRAM response
// arrives, aligns/extends load data and hands off to write-back.
module mem_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic [75:0]  EX_to_MEM_BUS,
  input  logic         EX_to_MEM_valid,
  output logic         MEM_allowin,
  input  logic         data_sram_data_ok,
  input  logic [31:0]  data_sram_rdata,
  output logic [106:0] MEM_to_WB_BUS,
  output logic         MEM_to_WB_valid,
  input  logic         WB_allowin,
  output logic [37:0]  MEM_RF_BUS,
  output logic         MEM_wait_data
);

  logic        mem_valid_q, mem_valid_d;
  logic [75:0] payload_q, payload_d;
  logic        data_got_q, data_got_d;
  logic [31:0] data_buf_q, data_buf_d;

  logic [31:0] pc;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [3:0]  load_op;
  logic        rfrom_mem;
  logic        mem_req;

  assign {pc, gr_we, dest, alu_result, load_op, rfrom_mem, mem_req} = payload_q;

  logic ready_go;
  logic leave;
  logic capture;

  assign ready_go        = !mem_req || data_got_q || data_sram_data_ok;
  assign MEM_allowin     = !mem_valid_q || (ready_go && WB_allowin);
  assign MEM_to_WB_valid = mem_valid_q && ready_go;
  assign MEM_wait_data   = mem_valid_q && mem_req && !data_got_q && !data_sram_data_ok;
  assign leave           = MEM_to_WB_valid && WB_allowin;
  // Only park the response when write-back stalls; otherwise it flows straight through.
  assign capture         = mem_valid_q && mem_req && data_sram_data_ok && !data_got_q && !WB_allowin;

  always_comb begin
    mem_valid_d = mem_valid_q;
    payload_d   = payload_q;
    data_got_d  = data_got_q;
    data_buf_d  = data_buf_q;
    if (MEM_allowin) mem_valid_d = EX_to_MEM_valid;
    if (MEM_allowin && EX_to_MEM_valid) payload_d = EX_to_MEM_BUS;
    if (leave) begin
      data_got_d = 1'b0;
    end else if (capture) begin
      data_got_d = 1'b1;
      data_buf_d = data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q <= 1'b0;
      payload_q   <= '0;
      data_got_q  <= 1'b0;
      data_buf_q  <= '0;
    end else begin
      mem_valid_q <= mem_valid_d;
      payload_q   <= payload_d;
      data_got_q  <= data_got_d;
      data_buf_q  <= data_buf_d;
    end
  end

  logic [31:0] raw;
  logic [1:0]  off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] mem_result;
  logic [31:0] final_result;

  assign raw      = data_got_q ? data_buf_q : data_sram_rdata;
  assign off      = alu_result[1:0];
  assign half_sel = alu_result[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    byte_sel = raw[7:0];
    case (off)
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      2'd3:    byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
  end

  // load_op[3] selects zero-extension; clear means sign-extension.
  always_comb begin
    mem_result = raw;
    if (load_op[2])
      mem_result = raw;
    else if (load_op[1])
      mem_result = {{16{!load_op[3] && half_sel[15]}}, half_sel};
    else if (load_op[0])
      mem_result = {{24{!load_op[3] && byte_sel[7]}}, byte_sel};
  end

  assign final_result  = rfrom_mem ? mem_result : alu_result;
  assign MEM_to_WB_BUS = {pc, gr_we, dest, mem_result, alu_result, load_op, rfrom_mem};
  assign MEM_RF_BUS    = {(gr_we && mem_valid_q) ? dest : 5'd0, rfrom_mem, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected WB payloads are queued on acceptance
// and compared when the stage hands off to write-back.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic [75:0]  ex_bus;
  logic         ex_valid;
  logic         MEM_allowin;
  logic         data_ok;
  logic [31:0]  rdata;
  logic [106:0] MEM_to_WB_BUS;
  logic         MEM_to_WB_valid;
  logic         wb_allowin;
  logic [37:0]  MEM_RF_BUS;
  logic         MEM_wait_data;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .EX_to_MEM_BUS     (ex_bus),
    .EX_to_MEM_valid   (ex_valid),
    .MEM_allowin       (MEM_allowin),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata),
    .MEM_to_WB_BUS     (MEM_to_WB_BUS),
    .MEM_to_WB_valid   (MEM_to_WB_valid),
    .WB_allowin        (wb_allowin),
    .MEM_RF_BUS        (MEM_RF_BUS),
    .MEM_wait_data     (MEM_wait_data)
  );

  typedef struct {
    logic [106:0] bus;
    logic         rfrom;
    logic [31:0]  fin;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   pops = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [75:0] mk(input logic [31:0] pc, input logic we, input logic [4:0] dst,
                                     input logic [31:0] alu, input logic [3:0] lop,
                                     input logic rfrom, input logic mreq);
    return {pc, we, dst, alu, lop, rfrom, mreq};
  endfunction

  function automatic logic [31:0] ref_ld(input logic [3:0] lop, input logic [1:0] off,
                                         input logic [31:0] r);
    logic [31:0] v;
    if (lop[2]) return r;
    if (lop[1]) begin
      v = (r >> (off[1] ? 16 : 0)) & 32'h0000FFFF;
      if (!lop[3] && v[15]) v = v | 32'hFFFF0000;
      return v;
    end
    if (lop[0]) begin
      v = (r >> (8 * off)) & 32'h000000FF;
      if (!lop[3] && v[7]) v = v | 32'hFFFFFF00;
      return v;
    end
    return r;
  endfunction

  task automatic nxt; @(posedge clk); #1; endtask
  task automatic smp; @(negedge clk); endtask

  // Offer a payload this cycle; raw is the SRAM word the test will later return.
  task automatic accept(input logic [75:0] b, input logic [31:0] r);
    exp_t e;
    logic [31:0] m;
    ex_valid = 1'b1;
    ex_bus   = b;
    smp();
    chk("accept", 128'(MEM_allowin), 128'(1));
    m       = ref_ld(b[5:2], b[7:6], r);
    e.bus   = {b[75:44], b[43], b[42:38], m, b[37:6], b[5:2], b[1]};
    e.rfrom = b[1];
    e.fin   = b[1] ? m : b[37:6];
    if (MEM_allowin) sb.push_back(e);
  endtask

  localparam logic [106:0] MEM_MASK = {38'h0, 32'hFFFFFFFF, 37'h0};

  always @(negedge clk) begin
    if (!reset && MEM_to_WB_valid && wb_allowin) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 128'(sb.size()), 128'(1));
      end else begin
        exp_t e;
        logic [106:0] msk;
        e   = sb.pop_front();
        msk = e.rfrom ? '0 : MEM_MASK;
        pops++;
        chk("wb_bus", 128'(MEM_to_WB_BUS & ~msk), 128'(e.bus & ~msk));
        chk("rf_final", 128'(MEM_RF_BUS[31:0]), 128'(e.fin));
      end
    end
  end

  initial begin
    int p0;
    reset = 1'b1; ex_valid = 1'b0; ex_bus = '0; data_ok = 1'b0; rdata = '0; wb_allowin = 1'b1;
    nxt(); nxt();
    smp();
    chk("rst_valid", 128'(MEM_to_WB_valid), 128'(0));
    chk("rst_allowin", 128'(MEM_allowin), 128'(1));
    chk("rst_rf_dest", 128'(MEM_RF_BUS[37:33]), 128'(0));
    chk("rst_wait", 128'(MEM_wait_data), 128'(0));
    nxt(); reset = 1'b0;

    // ALU op: one-cycle latency
    nxt(); accept(mk(32'h1C000000, 1'b1, 5'd5, 32'h12345678, 4'h0, 1'b0, 1'b0), 32'h0);
    nxt(); ex_valid = 1'b0; smp();
    chk("alu_valid", 128'(MEM_to_WB_valid), 128'(1));
    chk("alu_rf", 128'(MEM_RF_BUS), 128'({5'd5, 1'b0, 32'h12345678}));

    // ld.b sign- then zero-extended, data_ok three cycles after acceptance
    for (int z = 0; z < 2; z++) begin
      nxt(); accept(mk(32'h1C000004, 1'b1, 5'd7, 32'h00001002, z ? 4'b1001 : 4'b0001, 1'b1, 1'b1),
                    32'h00800000);
      for (int c = 1; c <= 2; c++) begin
        nxt(); ex_valid = 1'b0; smp();
        chk("ldb_wait", 128'(MEM_wait_data), 128'(1));
        chk("ldb_hold", 128'(MEM_to_WB_valid), 128'(0));
      end
      nxt(); data_ok = 1'b1; rdata = 32'h00800000; smp();
      chk("ldb_valid", 128'(MEM_to_WB_valid), 128'(1));
      chk("ldb_res", 128'(MEM_RF_BUS[31:0]), 128'(z ? 32'h00000080 : 32'hFFFFFF80));
      nxt(); data_ok = 1'b0; rdata = '0;
    end

    // ld.h buffered while WB stalls, then a new load enters as it departs
    nxt(); accept(mk(32'h1C000010, 1'b1, 5'd3, 32'h00002002, 4'b0010, 1'b1, 1'b1), 32'hBEEF1234);
    nxt(); ex_valid = 1'b0; wb_allowin = 1'b0; data_ok = 1'b1; rdata = 32'hBEEF1234; smp();
    chk("ldh_allowin0", 128'(MEM_allowin), 128'(0));
    nxt(); data_ok = 1'b0; rdata = 32'hDEADDEAD; smp();
    chk("ldh_got", 128'(dut.data_got_q), 128'(1));
    chk("ldh_held_allowin", 128'(MEM_allowin), 128'(0));
    chk("ldh_held_valid", 128'(MEM_to_WB_valid), 128'(1));
    chk("ldh_buf_res", 128'(MEM_RF_BUS[31:0]), 128'(32'hFFFFBEEF));
    nxt(); wb_allowin = 1'b1;
    accept(mk(32'h1C000014, 1'b1, 5'd4, 32'h00003000, 4'b0100, 1'b1, 1'b1), 32'hCAFEF00D);
    nxt(); ex_valid = 1'b0; smp();
    chk("swap_wait", 128'(MEM_wait_data), 128'(1));
    chk("swap_hold", 128'(MEM_to_WB_valid), 128'(0));
    nxt(); data_ok = 1'b1; rdata = 32'hCAFEF00D; smp();
    chk("swap_valid", 128'(MEM_to_WB_valid), 128'(1));
    nxt(); data_ok = 1'b0; rdata = '0;

    // back-to-back ALU ops, no bubbles
    p0 = pops;
    for (int i = 0; i < 6; i++) begin
      nxt(); accept(mk(32'h1C001000 + 32'(4 * i), 1'b1, 5'(i + 1), 32'(i * 32'h1111), 4'h0, 1'b0, 1'b0), 32'h0);
      if (i > 0) chk("b2b_valid", 128'(MEM_to_WB_valid), 128'(1));
    end
    nxt(); ex_valid = 1'b0; smp();
    chk("b2b_last", 128'(MEM_to_WB_valid), 128'(1));
    nxt(); smp();
    chk("b2b_count", 128'(pops - p0), 128'(6));

    // store waits for data_ok, never exposes a destination
    nxt(); accept(mk(32'h1C002000, 1'b0, 5'd9, 32'h00004000, 4'h0, 1'b0, 1'b1), 32'h0);
    for (int c = 1; c <= 2; c++) begin
      nxt(); ex_valid = 1'b0; smp();
      chk("st_hold", 128'(MEM_to_WB_valid), 128'(0));
      chk("st_allowin", 128'(MEM_allowin), 128'(0));
      chk("st_rf_dest", 128'(MEM_RF_BUS[37:33]), 128'(0));
    end
    nxt(); data_ok = 1'b1; rdata = 32'h55AA55AA; smp();
    chk("st_valid", 128'(MEM_to_WB_valid), 128'(1));
    chk("st_rf_dest_go", 128'(MEM_RF_BUS[37:33]), 128'(0));
    nxt(); data_ok = 1'b0; rdata = '0;

    // reset while a load waits for data
    nxt(); accept(mk(32'h1C003000, 1'b1, 5'd11, 32'h00005000, 4'b0100, 1'b1, 1'b1), 32'h0);
    nxt(); ex_valid = 1'b0; smp();
    chk("rw_wait", 128'(MEM_wait_data), 128'(1));
    nxt(); reset = 1'b1;
    nxt(); reset = 1'b0; smp();
    sb.delete();
    chk("rw_mem_valid", 128'(dut.mem_valid_q), 128'(0));
    chk("rw_valid", 128'(MEM_to_WB_valid), 128'(0));
    chk("rw_allowin", 128'(MEM_allowin), 128'(1));
    chk("rw_got", 128'(dut.data_got_q), 128'(0));

    // reset while data is buffered
    nxt(); accept(mk(32'h1C003004, 1'b1, 5'd12, 32'h00005004, 4'b0100, 1'b1, 1'b1), 32'h0);
    nxt(); ex_valid = 1'b0; wb_allowin = 1'b0; data_ok = 1'b1; rdata = 32'h13572468;
    nxt(); data_ok = 1'b0; smp();
    chk("rb_got", 128'(dut.data_got_q), 128'(1));
    nxt(); reset = 1'b1;
    nxt(); reset = 1'b0; wb_allowin = 1'b1; smp();
    sb.delete();
    chk("rb_got_clr", 128'(dut.data_got_q), 128'(0));
    chk("rb_valid", 128'(MEM_to_WB_valid), 128'(0));
    chk("rb_allowin", 128'(MEM_allowin), 128'(1));

    nxt(); nxt(); smp();
    chk("sb_drained", 128'(sb.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
